// File: rtl/ccx_pkg.sv
// Shared types for the ccx external-memory arbiter.
// Holds the FSM state enum, default bus widths and an index-width helper.
package ccx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int CCX_AW = 39;
    localparam int CCX_DW = 64;

    // Width of a port index; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ccx_rr_pick.sv
// Combinational round-robin pick: search starts one past ptr, wraps.
// Ports: req (request vector), ptr (last owner) -> gnt (one-hot), idx, any.
module ccx_rr_pick
    import ccx_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int IW     = idx_w(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NPORTS-1:0] gnt,
    output logic [IW-1:0]     idx,
    output logic              any
);

    logic [IW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            j = IW'((int'(ptr) + k) % NPORTS);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/ccx_emem_arbiter.sv
// N-port round-robin arbiter onto the single emem bus, with ownership lock
// and bus timeout. Ports: p_* requester side, emem_* bus side, busy, timeout_evt.
module ccx_emem_arbiter
    import ccx_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int AW      = CCX_AW,
    parameter int DW      = CCX_DW,
    parameter int TIMEOUT = 256
) (
    input  logic                   f_clk,
    input  logic                   g_reset,
    input  logic [NPORTS-1:0]      p_req,
    input  logic [NPORTS-1:0]      p_rtype,
    input  logic [NPORTS*AW-1:0]   p_addr,
    input  logic [NPORTS-1:0]      p_wen,
    input  logic [NPORTS*DW/8-1:0] p_strb,
    input  logic [NPORTS*DW-1:0]   p_wdata,
    output logic [NPORTS-1:0]      p_gnt,
    output logic [NPORTS-1:0]      p_err,
    output logic [DW-1:0]          p_rdata,
    output logic                   emem_req,
    output logic                   emem_rtype,
    output logic [AW-1:0]          emem_addr,
    output logic                   emem_wen,
    output logic [DW/8-1:0]        emem_strb,
    output logic [DW-1:0]          emem_wdata,
    input  logic                   emem_gnt,
    input  logic                   emem_err,
    input  logic [DW-1:0]          emem_rdata,
    output logic                   busy,
    output logic                   timeout_evt
);

    localparam int SW = DW / 8;
    localparam int IW = idx_w(NPORTS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [AW-1:0] addr_a  [NPORTS];
    logic [SW-1:0] strb_a  [NPORTS];
    logic [DW-1:0] wdata_a [NPORTS];

    for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
        assign addr_a[g]  = p_addr[g*AW +: AW];
        assign strb_a[g]  = p_strb[g*SW +: SW];
        assign wdata_a[g] = p_wdata[g*DW +: DW];
    end

    state_e        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          rtype_q, rtype_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [SW-1:0] strb_q, strb_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic [NPORTS-1:0] pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    ccx_rr_pick #(
        .NPORTS (NPORTS),
        .IW     (IW)
    ) u_pick (
        .req (p_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rtype_d     = rtype_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
        p_gnt       = '0;
        p_err       = '0;
        p_rdata     = '0;
        timeout_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BUSY;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    rtype_d = p_rtype[pick_idx];
                    addr_d  = addr_a[pick_idx];
                    wen_d   = p_wen[pick_idx];
                    strb_d  = strb_a[pick_idx];
                    wdata_d = wdata_a[pick_idx];
                end
            end
            ST_BUSY: begin
                // A grant in the expiry cycle still completes normally.
                if (emem_gnt) begin
                    p_gnt[owner_q] = 1'b1;
                    p_err[owner_q] = emem_err;
                    p_rdata        = emem_rdata;
                    req_d          = 1'b0;
                    state_d        = ST_IDLE;
                end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
                    p_gnt[owner_q] = 1'b1;
                    p_err[owner_q] = 1'b1;
                    timeout_evt    = 1'b1;
                    req_d          = 1'b0;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= IW'(NPORTS - 1);
            cnt_q   <= '0;
            req_q   <= 1'b0;
            rtype_q <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rtype_q <= rtype_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
        end
    end

    assign emem_req   = req_q;
    assign emem_rtype = rtype_q;
    assign emem_addr  = addr_q;
    assign emem_wen   = wen_q;
    assign emem_strb  = strb_q;
    assign emem_wdata = wdata_q;
    assign busy       = (state_q == ST_BUSY);

endmodule

// File: tb/tb_ccx_emem_arbiter.sv
// Directed bench for ccx_emem_arbiter (4 ports, timeout 8).
// Inputs change after posedge or at negedge; outputs sampled at negedge.
module tb_ccx_emem_arbiter;

    localparam int NP = 4;
    localparam int AW = 39;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic             f_clk = 1'b0;
    logic             g_reset;
    logic [NP-1:0]    p_req, p_rtype, p_wen;
    logic [NP*AW-1:0] p_addr;
    logic [NP*SW-1:0] p_strb;
    logic [NP*DW-1:0] p_wdata;
    logic [NP-1:0]    p_gnt, p_err;
    logic [DW-1:0]    p_rdata;
    logic             emem_req, emem_rtype, emem_wen;
    logic [AW-1:0]    emem_addr;
    logic [SW-1:0]    emem_strb;
    logic [DW-1:0]    emem_wdata;
    logic             emem_gnt, emem_err;
    logic [DW-1:0]    emem_rdata;
    logic             busy, timeout_evt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 f_clk = ~f_clk;

    ccx_emem_arbiter #(
        .NPORTS  (NP),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .f_clk       (f_clk),
        .g_reset     (g_reset),
        .p_req       (p_req),
        .p_rtype     (p_rtype),
        .p_addr      (p_addr),
        .p_wen       (p_wen),
        .p_strb      (p_strb),
        .p_wdata     (p_wdata),
        .p_gnt       (p_gnt),
        .p_err       (p_err),
        .p_rdata     (p_rdata),
        .emem_req    (emem_req),
        .emem_rtype  (emem_rtype),
        .emem_addr   (emem_addr),
        .emem_wen    (emem_wen),
        .emem_strb   (emem_strb),
        .emem_wdata  (emem_wdata),
        .emem_gnt    (emem_gnt),
        .emem_err    (emem_err),
        .emem_rdata  (emem_rdata),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge f_clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic rt, input logic [AW-1:0] a,
                            input logic we, input logic [SW-1:0] s,
                            input logic [DW-1:0] d);
        p_rtype[i]         = rt;
        p_addr[i*AW +: AW] = a;
        p_wen[i]           = we;
        p_strb[i*SW +: SW] = s;
        p_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        g_reset = 1'b1;
        p_req = '0; p_rtype = '0; p_wen = '0;
        p_addr = '0; p_strb = '0; p_wdata = '0;
        emem_gnt = 1'b0; emem_err = 1'b0; emem_rdata = '0;
        cyc(); cyc();
        @(negedge f_clk);
        chk("rst_req", 64'(emem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gnt", 64'(p_gnt), 64'd0);
        chk("rst_rdata", p_rdata, 64'd0);
        chk("rst_addr", 64'(emem_addr), 64'd0);
        g_reset = 1'b0;

        // Single read on port 0, grant two cycles after emem_req rises.
        set_port(0, 1'b0, 39'h10000, 1'b0, 8'h00, 64'd0);
        p_req = 4'b0001;
        cyc();
        @(negedge f_clk);
        chk("rd_req_c1", 64'(emem_req), 64'd1);
        chk("rd_addr_c1", 64'(emem_addr), 64'h10000);
        chk("rd_busy", 64'(busy), 64'd1);
        cyc();
        @(negedge f_clk);
        chk("rd_nognt_c2", 64'(p_gnt), 64'd0);
        chk("rd_rdata0_c2", p_rdata, 64'd0);
        cyc();
        emem_gnt = 1'b1;
        emem_rdata = 64'hDEADBEEF;
        @(negedge f_clk);
        chk("rd_gnt", 64'(p_gnt), 64'b0001);
        chk("rd_rdata", p_rdata, 64'hDEADBEEF);
        chk("rd_err", 64'(p_err), 64'd0);
        cyc();
        emem_gnt = 1'b0;
        p_req = '0;
        @(negedge f_clk);
        chk("rd_req_drop", 64'(emem_req), 64'd0);
        chk("rd_idle", 64'(busy), 64'd0);

        // Round robin from fresh reset, all four requesting, immediate gnt.
        g_reset = 1'b1;
        cyc();
        g_reset = 1'b0;
        for (int i = 0; i < NP; i++)
            set_port(i, 1'b0, AW'(39'h1000 * (i + 1)), 1'b0, 8'h00, 64'd0);
        p_req = 4'b1111;
        emem_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            @(negedge f_clk);
            chk("rr_gnt", 64'(p_gnt), 64'(1 << (i % 4)));
            chk("rr_addr", 64'(emem_addr), 64'(39'h1000 * ((i % 4) + 1)));
            cyc();
            @(negedge f_clk);
            chk("rr_dead", 64'(emem_req), 64'd0);
        end
        p_req = '0;
        emem_gnt = 1'b0;

        // Port 1 write held stable while port 2 requests mid-transaction.
        set_port(1, 1'b1, 39'h20000, 1'b1, 8'h0F, 64'h1122334455667788);
        p_req = 4'b0010;
        cyc();
        @(negedge f_clk);
        chk("wr_addr", 64'(emem_addr), 64'h20000);
        chk("wr_wen", 64'(emem_wen), 64'd1);
        chk("wr_rtype", 64'(emem_rtype), 64'd1);
        chk("wr_strb", 64'(emem_strb), 64'h0F);
        chk("wr_wdata", emem_wdata, 64'h1122334455667788);
        set_port(2, 1'b0, 39'h30000, 1'b0, 8'hFF, 64'd0);
        p_req = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge f_clk);
            chk("hold_addr", 64'(emem_addr), 64'h20000);
            chk("hold_wdata", emem_wdata, 64'h1122334455667788);
            chk("hold_nognt", 64'(p_gnt), 64'd0);
        end
        cyc();
        emem_gnt = 1'b1;
        @(negedge f_clk);
        chk("wr_gnt", 64'(p_gnt), 64'b0010);
        chk("wr_err", 64'(p_err), 64'd0);
        cyc();
        emem_gnt = 1'b0;
        p_req = 4'b0100;
        @(negedge f_clk);
        chk("p2_dead", 64'(emem_req), 64'd0);
        cyc();
        @(negedge f_clk);
        chk("p2_addr", 64'(emem_addr), 64'h30000);
        chk("p2_wen", 64'(emem_wen), 64'd0);

        // Bus error returned with the grant.
        emem_gnt = 1'b1;
        emem_err = 1'b1;
        #1;
        chk("err_gnt", 64'(p_gnt), 64'b0100);
        chk("err_err", 64'(p_err), 64'b0100);
        chk("err_noto", 64'(timeout_evt), 64'd0);
        cyc();
        emem_gnt = 1'b0;
        emem_err = 1'b0;
        p_req = '0;

        // Timeout: port 3 never granted.
        set_port(3, 1'b0, 39'h40000, 1'b0, 8'h00, 64'd0);
        p_req = 4'b1000;
        emem_rdata = 64'hCAFE;
        for (int c = 1; c <= TO; c++) begin
            cyc();
            @(negedge f_clk);
            if (c == 1) chk("to_req", 64'(emem_req), 64'd1);
            if (c == TO - 1) begin
                chk("to_early_gnt", 64'(p_gnt), 64'd0);
                chk("to_early_evt", 64'(timeout_evt), 64'd0);
            end
            if (c == TO) begin
                chk("to_gnt", 64'(p_gnt), 64'b1000);
                chk("to_err", 64'(p_err), 64'b1000);
                chk("to_evt", 64'(timeout_evt), 64'd1);
                chk("to_rdata", p_rdata, 64'd0);
            end
        end
        cyc();
        p_req = '0;
        emem_gnt = 1'b1;
        @(negedge f_clk);
        chk("late_gnt", 64'(p_gnt), 64'd0);
        chk("late_req", 64'(emem_req), 64'd0);
        chk("late_rdata", p_rdata, 64'd0);
        cyc();
        emem_gnt = 1'b0;

        // Grant exactly in the expiry cycle completes normally.
        p_req = 4'b0001;
        for (int c = 1; c <= TO; c++) begin
            cyc();
            if (c == TO) begin
                emem_gnt = 1'b1;
                emem_rdata = 64'h0123456789ABCDEF;
            end
            @(negedge f_clk);
            if (c == TO) begin
                chk("edge_gnt", 64'(p_gnt), 64'b0001);
                chk("edge_err", 64'(p_err), 64'd0);
                chk("edge_evt", 64'(timeout_evt), 64'd0);
                chk("edge_rdata", p_rdata, 64'h0123456789ABCDEF);
            end
        end
        cyc();
        p_req = '0;
        emem_gnt = 1'b0;
        @(negedge f_clk);
        chk("edge_drop", 64'(emem_req), 64'd0);

        // Reset in the middle of a port 1 transaction.
        p_req = 4'b0010;
        cyc();
        @(negedge f_clk);
        chk("mr_busy", 64'(busy), 64'd1);
        g_reset = 1'b1;
        cyc();
        @(negedge f_clk);
        chk("mr_req", 64'(emem_req), 64'd0);
        chk("mr_busy0", 64'(busy), 64'd0);
        chk("mr_gnt", 64'(p_gnt), 64'd0);
        g_reset = 1'b0;
        p_req = 4'b0011;
        cyc();
        @(negedge f_clk);
        chk("mr_port0", 64'(emem_addr), 64'h1000);
        emem_gnt = 1'b1;
        #1;
        chk("mr_gnt0", 64'(p_gnt), 64'b0001);
        cyc();
        emem_gnt = 1'b0;
        p_req = '0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
